// File: rtl/ttl_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus driven through per-requester octal buffers.
// Optional ARB_PARK_EN: the last owner's buffer stays enabled while idle so the bus never floats.
module ttl_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DEAD_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         G_bar,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_busy
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [1:0]    DEAD_INIT = 2'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
  localparam logic [N_REQ-1:0] ALL_HIGH = {N_REQ{1'b1}};
`ifdef ARB_PARK_EN
  localparam logic PARK_EN = 1'b1;
`else
  localparam logic PARK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, OWN = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [OW-1:0]     owner_r, owner_s, last_r, last_s, pick_s, repick_s;
  logic [1:0]        dead_r, dead_s;
  logic [HW-1:0]     hold_r, hold_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s, g_bar_r, g_bar_s, others_req_s;
  logic              busy_r, others_s, release_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // First set bit scanning base+1, base+2, ... with wrap; base itself is checked last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] base);
    logic [OW-1:0] p;
    logic          hit;
    int unsigned   k;
    p   = base;
    hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(base) + i) % N_REQ;
      if (!hit && r[k]) begin
        p   = OW'(k);
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return p;
  endfunction

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    dead_s       = dead_r;
    hold_s       = hold_r;
    pick_s       = rr_pick(req, last_r);
    others_req_s = req & ~onehot(owner_r);
    others_s     = |others_req_s;
    repick_s     = rr_pick(others_req_s, owner_r);
    release_s    = !req[owner_r] ||
                   ((MAX_HOLD != 0) && (hold_r == HOLD_LAST) && others_s);
    case (state_r)
      IDLE: begin
        if (|req) begin
          owner_s = pick_s;
          if ((DEAD_CYCLES == 0) || (PARK_EN && (pick_s == last_r))) begin
            state_s = OWN;
            hold_s  = '0;
          end else begin
            state_s = TURN;
            dead_s  = DEAD_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TURN: begin
        if (dead_r == 2'd0) begin
          state_s = OWN;
          hold_s  = '0;
        end else begin
          dead_s = dead_r - 2'd1;
        end
      end
      OWN: begin
        if (release_s && others_s) begin
          owner_s = repick_s;
          if (DEAD_CYCLES == 0) begin
            state_s = OWN;
            hold_s  = '0;
          end else begin
            state_s = TURN;
            dead_s  = DEAD_INIT;
          end
        end else if (release_s) begin
          state_s = IDLE;
        end else if (hold_r != HOLD_SAT) begin
          hold_s = hold_r + HW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    gnt_s  = '0;
    last_s = last_r;
    if (state_s == OWN) begin
      gnt_s   = onehot(owner_s);
      g_bar_s = ~gnt_s;
      last_s  = owner_s;
    end else if (PARK_EN && (state_s == IDLE)) begin
      g_bar_s = ~onehot(last_r);
    end else begin
      g_bar_s = ALL_HIGH;
    end
  end

  // State and output registers; reset releases the bus on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= '0;
      last_r  <= OW'(N_REQ - 1);
      dead_r  <= 2'd0;
      hold_r  <= '0;
      gnt_r   <= '0;
      g_bar_r <= ALL_HIGH;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      last_r  <= last_s;
      dead_r  <= dead_s;
      hold_r  <= hold_s;
      gnt_r   <= gnt_s;
      g_bar_r <= g_bar_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign gnt      = gnt_r;
  assign G_bar    = g_bar_r;
  assign owner    = owner_r;
  assign bus_busy = busy_r;
endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// Self-checking bench for ttl_bus_arbiter: vector table through a scoreboard queue,
// plus long round-robin, reset-in-tenure and unlimited-hold sequences.
module tb_ttl_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, G_bar;
  logic [1:0] owner;
  logic       bus_busy;
  logic [3:0] req_nh = 4'b0000;
  logic [3:0] gnt_nh, G_bar_nh;
  logic [1:0] owner_nh;
  logic       bus_busy_nh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttl_bus_arbiter #(.N_REQ(4), .DEAD_CYCLES(1), .MAX_HOLD(16)) u_dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .G_bar(G_bar),
    .owner(owner), .bus_busy(bus_busy));

  ttl_bus_arbiter #(.N_REQ(4), .DEAD_CYCLES(1), .MAX_HOLD(0)) u_nh (
    .clk(clk), .reset(reset), .req(req_nh), .gnt(gnt_nh), .G_bar(G_bar_nh),
    .owner(owner_nh), .bus_busy(bus_busy_nh));

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] gbar;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] gbar;
    logic [1:0] owner;
    logic       busy;
    logic       chk_owner;
  } exp_t;

  exp_t sb_q[$];

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic [3:0] r, input logic rst, input logic [3:0] eg,
                      input logic [3:0] eb, input logic [1:0] eo, input logic ebusy,
                      input logic co, input string nm);
    exp_t e;
    @(negedge clk);
    req   = r;
    reset = rst;
    e.gnt = eg; e.gbar = eb; e.owner = eo; e.busy = ebusy; e.chk_owner = co;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (gnt !== e.gnt || G_bar !== e.gbar || bus_busy !== e.busy ||
        (e.chk_owner && owner !== e.owner)) begin
      errors++;
      $display("FAIL %s: got gnt=%b G_bar=%b owner=%0d busy=%b, want gnt=%b G_bar=%b owner=%0d busy=%b",
               nm, gnt, G_bar, owner, bus_busy, e.gnt, e.gbar, e.owner, e.busy);
    end
  endtask

  task automatic chk_nh(input logic [3:0] eg, input string nm, input int cyc);
    checks++;
    if (gnt_nh !== eg || G_bar_nh !== ~eg) begin
      errors++;
      $display("FAIL %s cycle %0d: got gnt=%b G_bar=%b, want gnt=%b G_bar=%b",
               nm, cyc, gnt_nh, G_bar_nh, eg, ~eg);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    req    = 4'b0000;
    req_nh = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[18];
    logic [3:0] eg;
    logic [1:0] eo;
    int pos, k;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || G_bar !== 4'b1111 || owner !== 2'd0 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b G_bar=%b owner=%0d busy=%b, want 0000 1111 0 0",
               gnt, G_bar, owner, bus_busy);
    end
    reset = 1'b0;

`ifndef ARB_PARK_EN
    vt[0]  = '{4'b0001, 4'b0000, 4'b1111, 2'd0, 1'b1};
    vt[1]  = '{4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
    vt[2]  = '{4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
    vt[3]  = '{4'b0001, 4'b0000, 4'b1111, 2'd0, 1'b1};
    vt[4]  = '{4'b0101, 4'b0001, 4'b1110, 2'd0, 1'b1};
    vt[5]  = '{4'b0100, 4'b0000, 4'b1111, 2'd2, 1'b1};
    vt[6]  = '{4'b0100, 4'b0100, 4'b1011, 2'd2, 1'b1};
    vt[7]  = '{4'b1000, 4'b0000, 4'b1111, 2'd3, 1'b1};
    vt[8]  = '{4'b1000, 4'b1000, 4'b0111, 2'd3, 1'b1};
    vt[9]  = '{4'b0000, 4'b0000, 4'b1111, 2'd3, 1'b0};
    vt[10] = '{4'b0010, 4'b0000, 4'b1111, 2'd1, 1'b1};
    vt[11] = '{4'b0000, 4'b0010, 4'b1101, 2'd1, 1'b1};
    vt[12] = '{4'b0000, 4'b0000, 4'b1111, 2'd1, 1'b0};
    vt[13] = '{4'b1001, 4'b0000, 4'b1111, 2'd3, 1'b1};
    vt[14] = '{4'b1001, 4'b1000, 4'b0111, 2'd3, 1'b1};
    vt[15] = '{4'b0001, 4'b0000, 4'b1111, 2'd0, 1'b1};
    vt[16] = '{4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
    vt[17] = '{4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      step(vt[i].req, 1'b0, vt[i].gnt, vt[i].gbar, vt[i].owner, vt[i].busy, 1'b1,
           $sformatf("vec%0d", i));
    end
`else
    do_reset();
    step(4'b0010, 1'b0, 4'b0000, 4'b1111, 2'd1, 1'b1, 1'b1, "park_turn1");
    step(4'b0010, 1'b0, 4'b0010, 4'b1101, 2'd1, 1'b1, 1'b1, "park_own1");
    step(4'b0000, 1'b0, 4'b0000, 4'b1101, 2'd1, 1'b0, 1'b1, "park_idle_a");
    step(4'b0000, 1'b0, 4'b0000, 4'b1101, 2'd1, 1'b0, 1'b1, "park_idle_b");
    step(4'b0010, 1'b0, 4'b0010, 4'b1101, 2'd1, 1'b1, 1'b1, "park_skip_turn");
    step(4'b0000, 1'b0, 4'b0000, 4'b1101, 2'd1, 1'b0, 1'b1, "park_idle_c");
    step(4'b0100, 1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1, 1'b1, "park_leave");
    step(4'b0100, 1'b0, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b1, "park_own2");
    step(4'b0000, 1'b0, 4'b0000, 4'b1011, 2'd2, 1'b0, 1'b1, "park_idle_d");
`endif

    // Reset in the middle of owner 2's tenure
    do_reset();
    step(4'b0100, 1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1, 1'b1, "rst_turn");
    step(4'b0100, 1'b0, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b1, "rst_own");
    step(4'b0101, 1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b1, "rst_release");
    step(4'b0101, 1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1, 1'b1, "rst_regrant_turn");
    step(4'b0101, 1'b0, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b1, "rst_regrant_req0");

    // All four requesting: 16-cycle tenures 0,1,2,3,0 with one dead cycle between
    do_reset();
    for (int j = 0; j < 85; j++) begin
      eg = 4'b0000;
      eo = 2'd0;
      if (j > 0) begin
        pos = (j - 1) % 17;
        k   = ((j - 1) / 17) % 4;
        if (pos < 16) begin
          eg = 4'b0001 << k;
          eo = 2'(k);
        end else begin
          eg = 4'b0000;
        end
      end
      step(4'b1111, 1'b0, eg, ~eg, eo, 1'b1, (eg != 4'b0000), $sformatf("rr_cycle%0d", j));
    end

    // Unlimited hold: owner 0 keeps the bus while req[1] waits
    do_reset();
    for (int j = 0; j < 202; j++) begin
      @(negedge clk);
      req_nh = 4'b0011;
      @(posedge clk);
      #1;
      chk_nh((j == 0) ? 4'b0000 : 4'b0001, "nohold_keep", j);
    end
    @(negedge clk);
    req_nh = 4'b0010;
    @(posedge clk);
    #1;
    chk_nh(4'b0000, "nohold_turn", 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_nh(4'b0010, "nohold_grant1", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
